fetch_return: RTL
=================

# fetch_return

Instruction return stage sitting directly downstream of the fetch stage: it tracks every Avalon instruction read the fetch stage issues, captures the returned `readdata`, pairs it with its PC, and presents instructions in order to decode. It absorbs variable memory latency and decode stalls in a small in-order buffer, tells fetch when to stop issuing, and discards returns belonging to a flushed (mispredicted/branched-over) path.

## Interface
- `DEPTH`, 4: buffer entries (power of two, ≥2); bounds outstanding plus unconsumed instructions.
- `SWAP_BYTES`, 1: 1 = byte-reverse `readdata` into `instr` (little-endian bus to big-endian MIPS word); 0 = pass through.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `active`  in  1  CPU running; 0 freezes the block (no issue accepted, no pop, `instr_valid`=0).
- `req_valid`  in  1  fetch issued a read this cycle (fetch's registered `read`).
- `req_pc`  in  32  PC of that read (fetch's registered `address`).
- `readdatavalid`  in  1  Avalon read data returned this cycle.
- `readdata`  in  32  Avalon read data.
- `flush`  in  1  discard all buffered and in-flight instructions.
- `stall`  in  1  decode cannot accept this cycle.
- `instr`  out  32  head instruction.
- `instr_pc`  out  32  head PC.
- `instr_valid`  out  1  head entry filled and presentable.
- `fetch_stall`  out  1  fetch must not issue next cycle.
- `error`  out  1  sticky protocol error.

## Operation
- Circular buffer of `DEPTH` entries {pc, data, filled}; pointers `head` (oldest), `fill` (oldest unfilled), `tail` (next free); `count` = allocated entries (0..DEPTH); `discard` counter (0..DEPTH+1).
- Issue: `req_valid`&`active`&~`flush` allocates entry at `tail` with `req_pc`, filled=0; tail++.
- Return: `readdatavalid` with `discard`>0 decrements `discard`, data dropped. Otherwise fills entry at `fill` (data = byte-swapped if `SWAP_BYTES`), filled=1, fill++. Return with no unfilled entry and `discard`=0 → `error`=1, data dropped.
- Output: `instr_valid` = `active` & count>0 & head.filled; `instr`/`instr_pc` = head fields (combinational from buffer; don't-care when `instr_valid`=0).
- Pop: `instr_valid`&~`stall`&~`flush` → head++, count--.
- Issue and pop in same cycle: count unchanged. Issue, return and pop all legal together.
- Overflow: issue while count==DEPTH and no pop → `error`=1, request not allocated.
- `fetch_stall` = count ≥ DEPTH−1 (leaves one slot for the request fetch already has registered).
- Flush (priority over issue/pop): all entries freed (head=fill=tail, count=0). `discard` ← `discard` + unfilled entries + `req_valid` − (`readdatavalid`&nothing-to-discard?0:`readdatavalid`), i.e. every request whose data has not yet arrived, including one issued in the flush cycle, will be dropped on return; a same-cycle return consumes one of these.
- `active`=0: no allocate, no pop; returns still fill/discard (bus already committed). `error` unaffected.
- `error` cleared only by `reset`.

## Timing
- Reset values: `instr_valid`=0, `fetch_stall`=0, `error`=0, `instr`/`instr_pc` don't-care; count=0, discard=0, all pointers 0.
- Data returned at edge E (sampled `readdatavalid`) → `instr_valid`=1 in cycle after E if that entry is head; zero added latency.
- Consumption at edge where `instr_valid`&~`stall`; next entry visible the following cycle if filled (back-to-back one instr/cycle).
- `fetch_stall` registered-path-free function of count; reflects count after edge.
- `flush` at edge F: `instr_valid`=0 in cycle after F; first new-path issue may be sampled at F+1.
- Reset asserted mid-operation: all state cleared at that edge; returns after reset are counted as errors (memory must be idle around reset).

## Test plan
- Single issue pc=0x00000000, return readdata=0x78563412 two cycles later → `instr`=0x12345678, `instr_pc`=0, `instr_valid` one cycle, popped with `stall`=0.
- Back-to-back issues pc 0,4,8,C with 1-cycle latency, `stall`=0 → four consecutive valid cycles, PCs in order, `fetch_stall` never 1 with DEPTH=4 beyond count 3.
- Hold `stall`=1, issue until count=3 → `fetch_stall`=1; one more in-flight issue accepted (count=4); release stall → 4 pops in order, `fetch_stall` drops when count<3.
- Two requests outstanding (unreturned) + one issued same cycle as `flush` → next 3 `readdatavalid` dropped, `instr_valid` stays 0; new issue pc=0x100 then returns and is presented.
- Same cycle issue+return+pop at count=2 → count stays 2, order preserved.
- `readdatavalid` with empty buffer and discard=0 → `error`=1 and stays 1 until `reset`.

Source files
------------

// File: rtl/fetch_return.sv
// Return stage between instruction fetch and decode: tracks issued Avalon reads, pairs returned
// data with its PC and presents instructions in order, dropping returns from flushed paths.
module fetch_return #(
    parameter int unsigned DEPTH      = 4,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic        readdatavalid,
    input  logic [31:0] readdata,
    input  logic        flush,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_stall,
    output logic        error
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = $clog2(2 * DEPTH + 3);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, pending_q, pending_d;
    logic [DW-1:0]    discard_q, discard_d, flush_total;
    logic             error_q, error_d;

    logic        full, pop, issue, alloc, overflow;
    logic        ret_drop, ret_fill, ret_err, flush_err;
    logic [31:0] rdata_sw;

    assign rdata_sw = SWAP_BYTES ? {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]}
                                 : readdata;

    assign instr_valid = active & (count_q != '0) & filled_q[head_q];
    assign instr       = data_q[head_q];
    assign instr_pc    = pc_q[head_q];
    assign fetch_stall = count_q >= CW'(DEPTH - 1);
    assign error       = error_q;

    assign full     = count_q == CW'(DEPTH);
    assign pop      = instr_valid & ~stall & ~flush;
    assign issue    = req_valid & active & ~flush;
    // A pop frees the head slot in the same cycle, so a full buffer can still accept.
    assign alloc    = issue & (~full | pop);
    assign overflow = issue & full & ~pop;

    assign ret_drop = readdatavalid & (discard_q != '0);
    assign ret_fill = readdatavalid & ~ret_drop & (pending_q != '0);
    assign ret_err  = readdatavalid & ~ret_drop & (pending_q == '0);

    // Every request still owed data, including one issued in the flush cycle, gets dropped later.
    assign flush_total = discard_q + DW'(pending_q) + DW'(req_valid);
    assign flush_err   = readdatavalid & (flush_total == '0);

    always_comb begin
        head_d    = head_q;
        fill_d    = fill_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pending_d = pending_q;
        discard_d = discard_q;
        filled_d  = filled_q;
        error_d   = error_q | overflow;
        if (flush) begin
            head_d    = '0;
            fill_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pending_d = '0;
            filled_d  = '0;
            discard_d = flush_total - DW'(readdatavalid & ~flush_err);
            error_d   = error_d | flush_err;
        end else begin
            head_d    = head_q + PW'(pop);
            fill_d    = fill_q + PW'(ret_fill);
            tail_d    = tail_q + PW'(alloc);
            count_d   = count_q + CW'(alloc) - CW'(pop);
            pending_d = pending_q + CW'(alloc) - CW'(ret_fill);
            discard_d = discard_q - DW'(ret_drop);
            error_d   = error_d | ret_err;
            if (ret_fill) filled_d[fill_q] = 1'b1;
            if (alloc)    filled_d[tail_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            fill_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
            discard_q <= '0;
            filled_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            head_q    <= head_d;
            fill_q    <= fill_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            discard_q <= discard_d;
            filled_q  <= filled_d;
            error_q   <= error_d;
        end
    end

    // Payload storage needs no reset; the filled flags and count gate visibility.
    always_ff @(posedge clk) begin
        if (!reset && alloc) pc_q[tail_q] <= req_pc;
        if (!reset && !flush && ret_fill) data_q[fill_q] <= rdata_sw;
    end

endmodule
